// File: rtl/muldiv_hilo_sequencer.sv
// Multi-cycle radix-2 multiply / restoring divide engine that owns the HI/LO
// registers and interlocks the EX stage while an operation is in flight.
module muldiv_hilo_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       con,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  input  logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod;

  // Status and interlock decode straight from the state flops.
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIX);
  assign div_zero = (state_q == S_FIX) & dz_q;
  assign stall    = busy & (start | hilo_rd);
  assign hilo_out = hilo_sel ? lo_q : hi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    accept = start & (con[3:2] == 2'b11);
    a_neg  = con[1] & op_a[WIDTH-1];
    b_neg  = con[1] & op_b[WIDTH-1];
    a_mag  = a_neg ? (~op_a + WIDTH'(1)) : op_a;
    b_mag  = b_neg ? (~op_b + WIDTH'(1)) : op_b;

    // Multiply step: conditionally add multiplicand, shift product right.
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));

    // Divide step: shift dividend bit into remainder, subtract if it fits.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - mcand_q) : div_shift[WIDTH-1:0];

    prod = {acc_hi_q, acc_lo_q};
    if (neg_q) prod = ~prod + (2*WIDTH)'(1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d  = con[0];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          acc_hi_d  = '0;
          if (con[0]) begin
            mcand_d  = b_mag;
            acc_lo_d = a_mag;
          end else begin
            mcand_d  = a_mag;
            acc_lo_d = b_mag;
          end
          // Divide by zero skips iteration; result is staged for FIX.
          if (con[0] && (op_b == '0)) begin
            dz_d     = 1'b1;
            acc_hi_d = op_a;
            acc_lo_d = '1;
            state_d  = S_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_hi_d = div_rem;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        if (dz_q) begin
          hi_d = acc_hi_q;
          lo_d = acc_lo_q;
        end else if (is_div_q) begin
          lo_d = neg_q     ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
          hi_d = rem_neg_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Randomized self-checking bench for muldiv_hilo_sequencer against a
// 64-bit arithmetic reference model.
module tb_muldiv_hilo_sequencer;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    con;
  logic [W-1:0]  op_a, op_b;
  logic          hilo_rd, hilo_sel;
  logic [W-1:0]  hilo_out;
  logic          busy, stall, done, div_zero;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_hilo_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .con(con), .op_a(op_a), .op_b(op_b),
    .hilo_rd(hilo_rd), .hilo_sel(hilo_sel), .hilo_out(hilo_out),
    .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (c)
      4'b1100: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      4'b1110: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      4'b1101, 4'b1111: begin
        if (b == 0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else if (c == 4'b1101) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          p = 64'(q); lo = p[31:0];
          p = 64'(r); hi = p[31:0];
        end
      end
      default: ;
    endcase
  endtask

  task automatic wait_done(inout int k);
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic read_check(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    hilo_rd = 1'b1; hilo_sel = 1'b0; #1;
    chk({tag, "_hi"}, hilo_out, ehi);
    chk({tag, "_rd_stall"}, stall, 0);
    hilo_sel = 1'b1; #1;
    chk({tag, "_lo"}, hilo_out, elo);
    hilo_rd = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo;
    bit dz;
    int k;
    model(c, a, b, ehi, elo, dz);
    @(negedge clk);
    start = 1'b1; con = c; op_a = a; op_b = b;
    #1 chk({tag, "_idle_stall"}, stall, 0);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk({tag, "_busy1"}, busy, 1);
    wait_done(k);
    chk({tag, "_done_cyc"}, k, dz ? 1 : W + 1);
    chk({tag, "_dz"}, div_zero, dz);
    @(negedge clk);
    chk({tag, "_busy_off"}, busy, 0);
    read_check(tag, ehi, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] eh1, el1, eh2, el2, ra, rb;
    logic [3:0] c2;
    bit d1, d2;
    int k;

    rst = 1'b1; start = 1'b0; con = 4'b0; op_a = '0; op_b = '0;
    hilo_rd = 1'b0; hilo_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_hi", hilo_out, 0);
    rst = 1'b0;

    // Codes outside the mult/div group are ignored.
    @(negedge clk);
    start = 1'b1; con = 4'b0110; op_a = 32'd9; op_b = 32'd3;
    @(negedge clk);
    chk("ign_busy", busy, 0);
    start = 1'b0;

    run_op("umul", 4'b1100, 32'hFFFF_FFFF, 32'h2);
    run_op("smul", 4'b1110, 32'hFFFF_FFFD, 32'd7);
    run_op("sdiv", 4'b1111, 32'hFFFF_FFF9, 32'd2);
    run_op("udiv", 4'b1101, 32'd100, 32'd7);
    run_op("udiv0", 4'b1101, 32'd5, 32'd0);
    run_op("sdiv0", 4'b1111, 32'hFFFF_FF00, 32'd0);
    run_op("sdivmn", 4'b1111, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("smulmn", 4'b1110, 32'h8000_0000, 32'h8000_0000);

    // mfhi and a back-to-back start arriving mid-operation.
    model(4'b1100, 32'h1234_5678, 32'h9ABC_DEF1, eh1, el1, d1);
    c2 = 4'b1111; ra = 32'hFFFF_FF9C; rb = 32'd7;
    model(c2, ra, rb, eh2, el2, d2);
    @(negedge clk);
    start = 1'b1; con = 4'b1100; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF1;
    @(negedge clk);
    start = 1'b0; k = 1;
    while (k < 5) begin @(negedge clk); k++; end
    hilo_rd = 1'b1; hilo_sel = 1'b0;
    start = 1'b1; con = c2; op_a = ra; op_b = rb;
    #1 chk("ct_stall5", stall, 1);
    do begin
      @(negedge clk);
      k++;
      chk("ct_stall_hold", stall, 1);
    end while (!done && k < 100);
    chk("ct_done_cyc", k, W + 1);
    @(negedge clk);
    chk("ct_stall_idle", stall, 0);
    chk("ct_mfhi_new", hilo_out, eh1);
    hilo_rd = 1'b0;
    @(negedge clk);
    start = 1'b0; k = 1;
    chk("ct_busy2", busy, 1);
    wait_done(k);
    chk("ct2_done_cyc", k, W + 1);
    chk("ct2_dz", div_zero, d2);
    @(negedge clk);
    read_check("ct2", eh2, el2);

    // Reset in the middle of RUN clears HI/LO at once.
    @(negedge clk);
    start = 1'b1; con = 4'b1100; op_a = 32'd77; op_b = 32'd99;
    @(negedge clk);
    start = 1'b0; k = 1;
    while (k < 10) begin @(negedge clk); k++; end
    rst = 1'b1; #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    hilo_sel = 1'b0; #1 chk("mr_hi", hilo_out, 0);
    hilo_sel = 1'b1; #1 chk("mr_lo", hilo_out, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 4'b1100, 32'd77, 32'd99);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 4'b1100 | 4'($urandom_range(0, 3)), pick(), pick());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
